seq_display_fsm: RTL

//  Parametrised successor to the 5-step HEX sequence FSM. Steps through a

---
 rtl/seq_display_fsm_pkg.sv | 41 ++++
 rtl/seq_display_fsm_seg7_decode.sv | 26 ++
 rtl/seq_display_fsm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_display_fsm_pkg.sv
// Shared constants for the step-sequence display: segment codes, the
// power-on digit sequence and the direction encoding.
package seq_display_fsm_pkg;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_N0    = 7'b1000000;
    localparam logic [6:0] SEG_N1    = 7'b1111001;
    localparam logic [6:0] SEG_N2    = 7'b0100100;
    localparam logic [6:0] SEG_N3    = 7'b0110000;
    localparam logic [6:0] SEG_N4    = 7'b0011001;
    localparam logic [6:0] SEG_N5    = 7'b0010010;
    localparam logic [6:0] SEG_N6    = 7'b0000010;
    localparam logic [6:0] SEG_N7    = 7'b1111000;
    localparam logic [6:0] SEG_N8    = 7'b0000000;
    localparam logic [6:0] SEG_N9    = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned DEFAULT_LEN = 5;
    localparam logic [3:0]  DEFAULT_0   = 4'd5;
    localparam logic [3:0]  DEFAULT_1   = 4'd7;
    localparam logic [3:0]  DEFAULT_2   = 4'd9;
    localparam logic [3:0]  DEFAULT_3   = 4'd8;
    localparam logic [3:0]  DEFAULT_4   = 4'd3;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Tables deeper than the default sequence repeat it.
    function automatic logic [3:0] default_digit(input int unsigned i);
        case (i % DEFAULT_LEN)
            0:       return DEFAULT_0;
            1:       return DEFAULT_1;
            2:       return DEFAULT_2;
            3:       return DEFAULT_3;
            default: return DEFAULT_4;
        endcase
    endfunction

endpackage

// File: rtl/seq_display_fsm_seg7_decode.sv
// BCD to active-low 7-segment decoder; non-decimal codes blank the digit.
module seg7_decode
    import seq_display_fsm_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_N0;
            4'd1:    o_seg = SEG_N1;
            4'd2:    o_seg = SEG_N2;
            4'd3:    o_seg = SEG_N3;
            4'd4:    o_seg = SEG_N4;
            4'd5:    o_seg = SEG_N5;
            4'd6:    o_seg = SEG_N6;
            4'd7:    o_seg = SEG_N7;
            4'd8:    o_seg = SEG_N8;
            4'd9:    o_seg = SEG_N9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_display_fsm.sv
// Steps through a writable table of BCD digits on key presses or prescaler
// ticks, showing the current digit and its step index on two 7-seg displays.
module seq_display_fsm
    import seq_display_fsm_pkg::*;
#(
    parameter int unsigned N_STEPS  = 5,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned TICK_DIV = 50,
    parameter int unsigned CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_key_n,
    input  logic             dir,
    input  logic             auto_en,
    input  logic             wrap_en,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [3:0]       load_val,
    output logic [IDX_W-1:0] idx,
    output logic [6:0]       hex_digit,
    output logic [6:0]       hex_index,
    output logic             at_limit
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STEPS - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_seq [N_STEPS];

    logic             w_step_pulse;
    logic             w_tick;
    logic             w_adv;
    dir_e             w_dir;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [3:0]       w_digit;
    logic [3:0]       w_idx_bcd;

    // Key idles high; flops reset to "released" so reset never fakes a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= step_key_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_step_pulse = r_s3 & ~r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!auto_en || (r_cnt == TICK_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tick = auto_en && (r_cnt == TICK_LAST);
    assign w_adv  = w_step_pulse | w_tick;
    assign w_dir  = dir_e'(dir);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_adv) begin
            if (w_dir == DIR_UP) begin
                if (r_idx == LAST_IDX) begin
                    if (wrap_en) begin
                        w_idx_nxt = '0;
                    end
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end else begin
                if (r_idx == '0) begin
                    if (wrap_en) begin
                        w_idx_nxt = LAST_IDX;
                    end
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        at_limit = 1'b0;
        if (!wrap_en) begin
            at_limit = (w_dir == DIR_UP) ? (r_idx == LAST_IDX) : (r_idx == '0);
        end
    end

    // Address matching per entry keeps out-of-range load_idx writes harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_STEPS; i++) begin
                r_seq[i] <= default_digit(i);
            end
        end else begin
            for (int unsigned i = 0; i < N_STEPS; i++) begin
                if (load_en && (load_idx == IDX_W'(i))) begin
                    r_seq[i] <= load_val;
                end
            end
        end
    end

    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < N_STEPS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_seq[i];
            end
        end
    end

    assign w_idx_bcd = 4'(r_idx);
    assign idx       = r_idx;

    seg7_decode u_dec_digit (
        .i_bcd (w_digit),
        .o_seg (hex_digit)
    );

    seg7_decode u_dec_index (
        .i_bcd (w_idx_bcd),
        .o_seg (hex_index)
    );

endmodule
